// File: rtl/corelet_ctrl.sv
// corelet_ctrl: tile sequencer for the compute corelet.
// Fetches kernel rows, then activation rows, from xmem into L0. Issues
// weight-load and execute opcodes on the 34-bit inst bus and drains the
// OFIFO into pmem. One start pulse runs a whole tile, and a one-cycle done
// pulse ends it.
// Optional: define CORELET_CTRL_STALL_CNT_EN to add the stall_cnt output.
module corelet_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int n_act  = 36,
    parameter int cnt_w  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] kern_base,
    input  logic [addr_w-1:0] act_base,
    input  logic [addr_w-1:0] psum_base,
    input  logic              relu_en,
    input  logic              l0_full,
    input  logic              l0_ready,
    input  logic              ofifo_valid,
    input  logic              ofifo_full,
    output logic [33:0]       inst,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_a,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [addr_w-1:0] pmem_a,
    output logic              busy,
    output logic              done
`ifdef CORELET_CTRL_STALL_CNT_EN
    ,
    output logic [cnt_w+7:0]  stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KFLUSH,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [cnt_w-1:0]   fetch_cnt;
    logic [cnt_w-1:0]   rd_cnt;
    logic [cnt_w-1:0]   out_cnt;
    logic [cnt_w-1:0]   flush_cnt;
    logic [addr_w-1:0]  kern_q;
    logic [addr_w-1:0]  act_q;
    logic [addr_w-1:0]  psum_q;
    logic               relu_q;
    logic               l0_wr_q;

    logic               fetch_ph;
    logic [cnt_w-1:0]   tgt;
    logic               fetch_go;
    logic               feed_go;
    logic               drain_go;
    logic [addr_w-1:0]  fetch_base;

    // OFIFO full is a status input only; the drain is paced by ofifo_valid.
    logic               ofifo_full_unused;
    assign ofifo_full_unused = ofifo_full;

    // Per-cycle fetch/feed/drain decisions. These are combinational so that
    // each handshake reacts in the same cycle as the L0/OFIFO status it
    // depends on.
    always_comb begin
        fetch_ph   = (state == S_KLOAD) || (state == S_EXEC);
        tgt        = (state == S_KLOAD) ? cnt_w'(col) : cnt_w'(n_act);
        fetch_go   = fetch_ph && !l0_full && !l0_wr_q && (fetch_cnt < tgt);
        feed_go    = fetch_ph && l0_ready && (rd_cnt < tgt);
        drain_go   = ((state == S_EXEC) || (state == S_DRAIN)) && ofifo_valid
                     && (out_cnt < cnt_w'(n_act));
        fetch_base = (state == S_KLOAD) ? kern_q : act_q;
    end

    // Drive the memory ports and the inst bus from the decisions above.
    // Addresses are forced to 0 whenever the matching port is idle.
    always_comb begin
        inst      = '0;
        inst[1:0] = feed_go ? ((state == S_KLOAD) ? 2'b01 : 2'b10) : 2'b00;
        inst[2]   = l0_wr_q;
        inst[3]   = feed_go;
        inst[6]   = drain_go;
        inst[33]  = relu_q;
        xmem_cen  = !fetch_go;
        xmem_a    = fetch_go ? (fetch_base + addr_w'(fetch_cnt)) : '0;
        pmem_cen  = !drain_go;
        pmem_wen  = !drain_go;
        pmem_a    = drain_go ? (psum_q + addr_w'(out_cnt)) : '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Tile FSM, counters and captured tile configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            fetch_cnt <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            kern_q    <= '0;
            act_q     <= '0;
            psum_q    <= '0;
            relu_q    <= 1'b0;
            l0_wr_q   <= 1'b0;
        end else begin
            // xmem has one cycle of read latency, so the L0 write follows the issue
            l0_wr_q <= fetch_go;
            if (fetch_go) fetch_cnt <= fetch_cnt + cnt_w'(1);
            if (feed_go)  rd_cnt    <= rd_cnt + cnt_w'(1);
            if (drain_go) out_cnt   <= out_cnt + cnt_w'(1);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        kern_q    <= kern_base;
                        act_q     <= act_base;
                        psum_q    <= psum_base;
                        relu_q    <= relu_en;
                        fetch_cnt <= '0;
                        rd_cnt    <= '0;
                        out_cnt   <= '0;
                        flush_cnt <= '0;
                        state     <= S_KLOAD;
                    end
                end
                S_KLOAD: begin
                    // The fetch/feed counters are cleared here rather than on EXEC
                    // entry; nothing touches them during the flush.
                    if (feed_go && (rd_cnt == cnt_w'(col - 1))) begin
                        fetch_cnt <= '0;
                        rd_cnt    <= '0;
                        flush_cnt <= '0;
                        state     <= S_KFLUSH;
                    end
                end
                S_KFLUSH: begin
                    flush_cnt <= flush_cnt + cnt_w'(1);
                    if (flush_cnt == cnt_w'(row + col - 1)) state <= S_EXEC;
                end
                S_EXEC: begin
                    if (feed_go && (rd_cnt == cnt_w'(n_act - 1))) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_cnt == cnt_w'(n_act)) state <= S_DONE;
                end
                S_DONE: begin
                    relu_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CORELET_CTRL_STALL_CNT_EN
    // Count busy cycles lost to L0 backpressure or to waiting on the OFIFO in DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cnt <= '0;
        end else if (busy && ((fetch_ph && l0_full && !l0_wr_q && (fetch_cnt < tgt))
                     || ((state == S_DRAIN) && !ofifo_valid && (out_cnt < cnt_w'(n_act))))) begin
            stall_cnt <= stall_cnt + (cnt_w+8)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: random L0/OFIFO behaviour against a transaction-level
// model of one tile (expected address lists, opcode counts, flush length).
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int NACT = 36;
    localparam int L0_DEPTH = 16;
    localparam logic [33:0] RSV_MASK = 34'h1_FFFF_FFB0;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] kern_base, act_base, psum_base;
    logic          relu_en, l0_full, l0_ready, ofifo_valid, ofifo_full;
    logic [33:0]   inst;
    logic          xmem_cen, pmem_cen, pmem_wen, busy, done;
    logic [AW-1:0] xmem_a, pmem_a;

    int checks = 0;
    int errors = 0;

    corelet_ctrl #(.row(ROW), .col(COL), .addr_w(AW), .n_act(NACT), .cnt_w(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .kern_base(kern_base), .act_base(act_base), .psum_base(psum_base),
        .relu_en(relu_en), .l0_full(l0_full), .l0_ready(l0_ready),
        .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
        .inst(inst), .xmem_cen(xmem_cen), .xmem_a(xmem_a),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inst"}, 64'(inst), 64'd0);
        check({tag, "_xcen"}, 64'(xmem_cen), 64'd1);
        check({tag, "_xa"}, 64'(xmem_a), 64'd0);
        check({tag, "_pcen"}, 64'(pmem_cen), 64'd1);
        check({tag, "_pwen"}, 64'(pmem_wen), 64'd1);
        check({tag, "_pa"}, 64'(pmem_a), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // One tile: L0 is modelled as an occupancy count, the OFIFO as a count of
    // produced-but-undrained rows (one per execute read).
    task automatic run_tile(input logic [AW-1:0] kb, input logic [AW-1:0] ab,
                            input logic [AW-1:0] pb, input bit relu,
                            input bit do_hold, input int abort_at);
        int l0_cnt = 0, avail = 0, out_n = 0, xrd_n = 0, krd_n = 0, erd_n = 0;
        int done_n = 0, gap = 0, hold_left = 0, cyc = 0;
        bit prev_issue = 0, flushing = 0, held = 0, finished = 0, aborted = 0;
        bit rand_full;
        logic [AW-1:0] exp_a;

        @(negedge clk);
        kern_base = kb; act_base = ab; psum_base = pb; relu_en = relu;
        start = 1'b1; l0_full = 1'b0; l0_ready = 1'b0; ofifo_valid = 1'b0;

        while (!finished && cyc < 2000) begin
            @(negedge clk);
            start = (cyc == 30);   // must be ignored while busy
            rand_full = (krd_n == COL && xrd_n == COL) ? 1'b0
                        : (cyc > 0 && $urandom_range(0, 3) == 0);
            l0_full = (hold_left > 0) || (l0_cnt >= L0_DEPTH) || rand_full;
            l0_ready = (l0_cnt > 0);
            ofifo_valid = (avail > 0) && ($urandom_range(0, 2) != 0);
            #1;

            if (cyc == 0) check("first_xrd_cen", 64'(xmem_cen), 64'd0);
            check("busy", 64'(busy), 64'(done_n == 0));
            check("relu", 64'(inst[33]), 64'((done_n == 0) ? relu : 1'b0));
            check("inst_rsv", 64'(inst & RSV_MASK), 64'd0);
            check("l0_wr", 64'(inst[2]), 64'(prev_issue));

            if (hold_left > 0) begin
                check("hold_xcen", 64'(xmem_cen), 64'd1);
                check("hold_l0wr", 64'(inst[2]), 64'd0);
            end

            if (flushing) begin
                if (!xmem_cen) begin
                    check("flush_len", 64'(gap), 64'(ROW + COL));
                    flushing = 0;
                end else begin
                    gap++;
                    check("flush_idle", 64'(inst[3:0]), 64'd0);
                end
            end

            if (!xmem_cen) begin
                check("xrd_notfull", 64'(l0_full), 64'd0);
                exp_a = (xrd_n < COL) ? kb + AW'(xrd_n) : ab + AW'(xrd_n - COL);
                check("xmem_a", 64'(xmem_a), 64'(exp_a));
                xrd_n++;
            end

            if (inst[3]) begin
                check("l0_rd_ready", 64'(l0_ready), 64'd1);
                check("inst_w", 64'(inst[1:0]), (krd_n < COL) ? 64'd1 : 64'd2);
                if (krd_n < COL) begin
                    krd_n++;
                    if (krd_n == COL) begin flushing = 1; gap = 0; end
                end else begin
                    erd_n++;
                    avail++;
                end
            end else begin
                check("inst_w_idle", 64'(inst[1:0]), 64'd0);
            end

            check("ofifo_rd", 64'(inst[6]), 64'(ofifo_valid && out_n < NACT));
            if (inst[6]) begin
                check("pmem_cen", 64'(pmem_cen), 64'd0);
                check("pmem_wen", 64'(pmem_wen), 64'd0);
                check("pmem_a", 64'(pmem_a), 64'(pb + AW'(out_n)));
                out_n++;
                avail--;
            end else begin
                check("pmem_idle", 64'(pmem_cen), 64'd1);
            end

            if (done) begin
                check("done_outs", 64'(out_n), 64'(NACT));
                check("done_erd", 64'(erd_n), 64'(NACT));
                done_n++;
            end else if (done_n > 0) begin
                finished = 1;
            end

            l0_cnt = l0_cnt + int'(inst[2]) - int'(inst[3]);
            check("l0_bounds", 64'(l0_cnt > L0_DEPTH || l0_cnt < 0), 64'd0);
            prev_issue = !xmem_cen;

            if (hold_left > 0) hold_left--;
            else if (do_hold && !held && erd_n >= 10 && xmem_cen) begin
                hold_left = 10;
                held = 1;
            end

            if (abort_at > 0 && erd_n >= abort_at) begin
                start = 1'b0;
                reset = 1'b0;
                #1;
                check_reset_values("abort");
                @(negedge clk);
                reset = 1'b1;
                aborted = 1;
                finished = 1;
            end
            cyc++;
        end

        if (!finished) check("timeout", 64'd1, 64'd0);
        if (!aborted) begin
            check("n_xrd", 64'(xrd_n), 64'(COL + NACT));
            check("n_krd", 64'(krd_n), 64'(COL));
            check("n_erd", 64'(erd_n), 64'(NACT));
            check("n_pwr", 64'(out_n), 64'(NACT));
            check("n_done", 64'(done_n), 64'd1);
            if (do_hold) check("hold_seen", 64'(held), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; kern_base = '0; act_base = '0; psum_base = '0;
        relu_en = 1'b0; l0_full = 1'b0; l0_ready = 1'b0; ofifo_valid = 1'b0; ofifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;

        run_tile(11'h000, 11'h100, 11'h200, 1'b0, 1'b1, 0);
        run_tile(11'h040, 11'h100, 11'h200, 1'b1, 1'b0, 5);
        run_tile(11'h010, 11'h100, 11'h200, 1'b1, 1'b0, 0);
        run_tile(AW'($urandom_range(0, 1900)), AW'($urandom_range(0, 1900)),
                 AW'($urandom_range(0, 1900)), 1'($urandom_range(0, 1)), 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Sequencer that drives the compute corelet's instruction and data-movement interface. It is the initiator of the 34-bit inst bus that the corelet consumes.
- Fetches kernel rows and then activation rows from the activation SRAM (xmem) into L0, issues weight-load and execute opcodes to the MAC array, and drains the OFIFO into the psum SRAM (pmem).
- One start pulse runs one full tile: kernel load, flush, execute, drain. A one-cycle done pulse ends the tile.

Parameters:
- row, 8, MAC array rows / L0 lanes
- col, 8, MAC array columns; also the number of kernel rows loaded per tile
- addr_w, 11, xmem/pmem address width
- n_act, 36, activation rows per tile; equals the number of output vectors per tile
- cnt_w, 8, width of internal counters; must satisfy 2^cnt_w > max(n_act, col+row)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse, begin tile; sampled only in IDLE
- kern_base  in  addr_w  xmem base address of kernel rows; captured at start
- act_base  in  addr_w  xmem base address of activation rows; captured at start
- psum_base  in  addr_w  pmem base address for outputs; captured at start
- relu_en  in  1  copied to inst[33] for the whole tile
- l0_full  in  1  L0 cannot accept a write
- l0_ready  in  1  L0 holds at least one row
- ofifo_valid  in  1  OFIFO head row is valid
- ofifo_full  in  1  OFIFO full (status only)
- inst  out  34  [1:0] inst_w (01 = kernel load, 10 = execute), [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] sfu mode; all other bits 0
- xmem_cen  out  1  xmem chip enable, active-low
- xmem_a  out  addr_w  xmem read address
- pmem_cen  out  1  pmem chip enable, active-low
- pmem_wen  out  1  pmem write enable, active-low
- pmem_a  out  addr_w  pmem write address
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse on completion

Behaviour:
- Reset values: all inst bits 0, xmem_cen=1, pmem_cen=1, pmem_wen=1, all addresses 0, busy=0, done=0, state=IDLE, all counters 0.
- Reset asserted mid-tile aborts immediately to these values. No partial tile resumes.
- States and transitions:
  - IDLE -> KLOAD on start.
  - KLOAD -> KFLUSH once col rows have been read out of L0 with inst_w=01.
  - KFLUSH -> EXEC after exactly row+col cycles with inst[3:0]=0.
  - EXEC -> DRAIN once n_act rows have been read out of L0 with inst_w=10.
  - DRAIN -> DONE once out_cnt==n_act.
  - DONE -> IDLE after 1 cycle; done=1 only in DONE.
- Fetch, active in KLOAD and EXEC:
  - A read is issued (xmem_cen=0, xmem_a=base+fetch_cnt) when l0_full==0, no read is in flight, and fetch_cnt < target (col in KLOAD, n_act in EXEC).
  - xmem latency is 1 cycle, so l0_wr=1 in the cycle after issue. At most one read is in flight, giving peak fill of 1 row per 2 cycles.
  - fetch_cnt resets to 0 on entry to EXEC.
- Feed: l0_rd=1 in any KLOAD/EXEC cycle where l0_ready==1 and rd_cnt < target. inst_w is driven in that same cycle and is 00 otherwise.
- Drain, active in EXEC and DRAIN:
  - Whenever ofifo_valid==1 and out_cnt<n_act: ofifo_rd=1, pmem_cen=0, pmem_wen=0, pmem_a=psum_base+out_cnt, then out_cnt increments.
  - Write data is ofifo_out routed outside this block.
- Simultaneous events: fetch, feed, and drain are independent and may all fire in the same cycle.
- start is ignored while busy. Counters do not wrap within a tile.
- inst[33] = relu_en captured at start, held until IDLE.

Optional Feature:
- Macro CORELET_CTRL_STALL_CNT_EN.
- When defined, adds output stall_cnt (cnt_w+8 bits). It is cleared at start and increments every busy cycle in which a fetch was blocked solely by l0_full or the DRAIN state waited with ofifo_valid==0. It holds its value after done.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 -> inst=0, xmem_cen=1, pmem_cen=1, busy=0. Release and pulse start with kern_base=0x000 -> next cycle xmem_cen=0, xmem_a=0x000, then l0_wr=1 one cycle later.
- Kernel phase with L0 model (depth 16): 8 reads at xmem_a 0..7, 8 l0_rd cycles with inst[1:0]=01, then exactly 16 cycles of inst[3:0]=0.
- Execute with act_base=0x100, n_act=36 -> xmem_a 0x100..0x123 each read once. Exactly 36 l0_rd cycles carry inst[1:0]=10.
- Backpressure: hold l0_full=1 for 10 cycles mid-EXEC -> no xmem reads and no l0_wr during the hold. Fetch resumes at the next address with none skipped or duplicated.
- Drain with psum_base=0x200: OFIFO model emits 36 valid rows with random gaps -> 36 pmem writes at 0x200..0x223, then done=1 for exactly 1 cycle and busy=0.
- Abort and restart: assert reset during EXEC -> all outputs return to reset values at once. A fresh start completes a full tile correctly; with relu_en=1, inst[33]=1 for the whole tile.
